// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline (load-use, taken branch, data-memory wait).
// Latency: controls are combinational from State and inputs; State advances on posedge CLK.
// Backpressure: MemReq_EXMEM && !MemReady freezes PC..EX/MEM and bubbles MEM/WB; the access is aborted after MEM_TIMEOUT cycles.
//
// Ports:
//   CLK, RST                  clock and asynchronous active-high reset
//   rs_ID, rt_ID, UsesRt_ID   source registers of the instruction in ID
//   rw_IDEX, MemRead_IDEX     destination and load flag of the instruction in ID/EX
//   BranchTaken_EX            taken branch/jump resolved in EX
//   MemReq_EXMEM, MemReady    data-memory handshake for the access in EX/MEM
//   *Write/*Flush/*Bubble     pipeline register controls
//   MemFault                  one-cycle pulse when a memory access times out
//   State                     current state (RUN=0, LUSTALL=1, MEMWAIT=2)
// Optional: define STALL_COUNT_EN to add StallCount[31:0] (saturating) and FlushCount[15:0] (wrapping).
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       UsesRt_ID,
  input  logic [4:0] rw_IDEX,
  input  logic       MemRead_IDEX,
  input  logic       BranchTaken_EX,
  input  logic       MemReq_EXMEM,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXWrite,
  output logic       IDEXBubble,
  output logic       EXMEMWrite,
  output logic       MEMWBBubble,
  output logic       MemFault,
  output logic [1:0] State
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [15:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [7:0] STALL_LAST  = 8'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] scnt_q, scnt_d;

  logic hazard;
  logic mem_wait;

  // Register zero is never a real dependency.
  assign hazard = MemRead_IDEX && (rw_IDEX != 5'd0) &&
                  ((rw_IDEX == rs_ID) || (UsesRt_ID && (rw_IDEX == rt_ID)));
  assign mem_wait = MemReq_EXMEM && !MemReady;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      scnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    MemFault    = 1'b0;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    scnt_d      = scnt_q;

    case (state_q)
      RUN, LUSTALL: begin
        if (mem_wait) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMWrite  = 1'b0;
          MEMWBBubble = 1'b1;
          state_d     = MEMWAIT;
          wcnt_d      = 8'd1;
          scnt_d      = 8'd0;
        end else if (BranchTaken_EX) begin
          // A taken branch squashes the stalled instruction, so it also ends a load-use stall.
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
          state_d    = RUN;
          scnt_d     = 8'd0;
        end else if (hazard || (state_q == LUSTALL)) begin
          // In LUSTALL the load has left ID/EX, so the stall is held by the counter, not the hazard term.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          if (state_q == RUN) begin
            if (MULTI_STALL) begin
              state_d = LUSTALL;
              scnt_d  = 8'd1;
            end
          end else if (scnt_q >= STALL_LAST) begin
            state_d = RUN;
            scnt_d  = 8'd0;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end

      MEMWAIT: begin
        // Branch and hazard inputs are not looked at here; RUN re-evaluates them.
        if (!MemReq_EXMEM || MemReady) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q >= TIMEOUT_CNT) begin
          // Drop the access: EX/MEM moves on while MEM/WB receives a bubble.
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          MEMWBBubble = 1'b1;
          MemFault    = 1'b1;
          state_d     = RUN;
          wcnt_d      = 8'd0;
        end else begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMWrite  = 1'b0;
          MEMWBBubble = 1'b1;
          wcnt_d      = wcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
        scnt_d  = 8'd0;
      end
    endcase

    // Reset forces default controls immediately, even if the inputs still request a stall.
    if (RST) begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXWrite   = 1'b1;
      IDEXBubble  = 1'b0;
      EXMEMWrite  = 1'b1;
      MEMWBBubble = 1'b0;
      MemFault    = 1'b0;
    end
  end

  assign State = state_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (IFIDFlush) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
